// File: rtl/pll_reconfig_seq.sv
// PLL reconfiguration sequencer: on a mode request, streams the mode, table and
// start writes to the PLL management port, then waits for lock with bounded PLL-reset retries.
module pll_reconfig_seq #(
    parameter int unsigned NUM_MODES    = 4,
    parameter int unsigned MAX_WRITES   = 16,
    parameter int unsigned ADDR_W       = 6,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned MODE_ADDR    = 0,
    parameter int unsigned START_ADDR   = 2,
    parameter int unsigned LOCK_TIMEOUT = 65535,
    parameter int unsigned MAX_RETRY    = 3,
    parameter int unsigned RST_CYCLES   = 16,
    localparam int unsigned MW = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1,
    localparam int unsigned IW = (MAX_WRITES > 1) ? $clog2(MAX_WRITES) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [MW-1:0]     mode_req,
    input  logic              mode_req_valid,
    output logic              mode_req_ready,
    output logic [MW-1:0]     tbl_mode,
    output logic [IW-1:0]     tbl_index,
    input  logic [ADDR_W-1:0] tbl_addr,
    input  logic [DATA_W-1:0] tbl_data,
    input  logic              tbl_last,
    output logic [ADDR_W-1:0] mgmt_address,
    output logic [DATA_W-1:0] mgmt_writedata,
    output logic              mgmt_write,
    input  logic              mgmt_waitrequest,
    input  logic              pll_locked,
    output logic              pll_rst,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [MW-1:0]     cur_mode
);

    localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int unsigned TW = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;
    localparam int unsigned CW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    localparam logic [MW:0]       MODE_LIM  = (MW + 1)'(NUM_MODES);
    localparam logic [IW-1:0]     IDX_LAST  = IW'(MAX_WRITES - 1);
    localparam logic [TW-1:0]     TMO       = TW'(LOCK_TIMEOUT);
    localparam logic [RW-1:0]     RETRY_MAX = RW'(MAX_RETRY);
    localparam logic [CW-1:0]     RST_LAST  = CW'(RST_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_MODE, S_LOAD, S_START, S_WAIT_LOCK, S_PRST, S_DONE, S_FAIL
    } state_t;

    state_t              r_state, w_state;
    logic                r_lk_meta, r_lk;
    logic [MW-1:0]       r_mode, w_mode;
    logic [IW-1:0]       r_idx, w_idx;
    logic [TW-1:0]       r_timer, w_timer;
    logic [RW-1:0]       r_retry, w_retry;
    logic [CW-1:0]       r_rst_cnt, w_rst_cnt;
    logic                r_wr, w_wr;
    logic [ADDR_W-1:0]   r_addr, w_addr;
    logic [DATA_W-1:0]   r_data, w_data;
    logic                r_pll_rst, w_pll_rst;
    logic                r_busy, w_busy;
    logic                r_done, w_done;
    logic                r_error, w_error;
    logic [MW-1:0]       r_cur_mode, w_cur_mode;
    logic                r_ready, w_ready;
    logic                w_wr_done;

    assign w_wr_done = r_wr && !mgmt_waitrequest;

    // Next-state and next-output logic; every write state issues once, then waits for completion
    always_comb begin
        w_state    = r_state;
        w_mode     = r_mode;
        w_idx      = r_idx;
        w_timer    = r_timer;
        w_retry    = r_retry;
        w_rst_cnt  = r_rst_cnt;
        w_wr       = r_wr;
        w_addr     = r_addr;
        w_data     = r_data;
        w_pll_rst  = 1'b0;
        w_done     = 1'b0;
        w_error    = r_error;
        w_cur_mode = r_cur_mode;

        case (r_state)
            S_IDLE: begin
                if (mode_req_valid && r_ready) begin
                    w_mode  = mode_req;
                    w_error = 1'b0;
                    w_retry = '0;
                    w_idx   = '0;
                    if ({1'b0, mode_req} >= MODE_LIM) w_state = S_FAIL;
                    else                              w_state = S_MODE;
                end
            end
            S_MODE: begin
                if (!r_wr) begin
                    w_wr   = 1'b1;
                    w_addr = ADDR_W'(MODE_ADDR);
                    w_data = '0;
                end else if (w_wr_done) begin
                    w_wr    = 1'b0;
                    w_idx   = '0;
                    w_state = S_LOAD;
                end
            end
            S_LOAD: begin
                if (!r_wr) begin
                    w_wr   = 1'b1;
                    w_addr = tbl_addr;
                    w_data = tbl_data;
                end else if (w_wr_done) begin
                    w_wr = 1'b0;
                    if (tbl_last || (r_idx == IDX_LAST)) w_state = S_START;
                    else                                 w_idx   = r_idx + IW'(1);
                end
            end
            S_START: begin
                if (!r_wr) begin
                    w_wr   = 1'b1;
                    w_addr = ADDR_W'(START_ADDR);
                    w_data = '0;
                end else if (w_wr_done) begin
                    w_wr    = 1'b0;
                    w_timer = '0;
                    w_state = S_WAIT_LOCK;
                end
            end
            S_WAIT_LOCK: begin
                if (r_lk && (r_timer != '0)) begin
                    w_done     = 1'b1;
                    w_cur_mode = r_mode;
                    w_state    = S_DONE;
                end else if (r_timer == TMO) begin
                    if (r_retry < RETRY_MAX) begin
                        w_pll_rst = 1'b1;
                        w_rst_cnt = '0;
                        w_state   = S_PRST;
                    end else begin
                        w_state = S_FAIL;
                    end
                end else begin
                    w_timer = r_timer + TW'(1);
                end
            end
            S_PRST: begin
                if (r_rst_cnt == RST_LAST) begin
                    w_retry = r_retry + RW'(1);
                    w_timer = '0;
                    w_state = S_WAIT_LOCK;
                end else begin
                    w_pll_rst = 1'b1;
                    w_rst_cnt = r_rst_cnt + CW'(1);
                end
            end
            S_DONE: w_state = S_IDLE;
            S_FAIL: begin
                w_error = 1'b1;
                w_state = S_IDLE;
            end
            default: w_state = S_IDLE;
        endcase

        w_busy  = (w_state != S_IDLE);
        w_ready = (w_state == S_IDLE);
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_lk_meta  <= 1'b0;
            r_lk       <= 1'b0;
            r_mode     <= '0;
            r_idx      <= '0;
            r_timer    <= '0;
            r_retry    <= '0;
            r_rst_cnt  <= '0;
            r_wr       <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
            r_pll_rst  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_cur_mode <= '0;
            r_ready    <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_lk_meta  <= pll_locked;
            r_lk       <= r_lk_meta;
            r_mode     <= w_mode;
            r_idx      <= w_idx;
            r_timer    <= w_timer;
            r_retry    <= w_retry;
            r_rst_cnt  <= w_rst_cnt;
            r_wr       <= w_wr;
            r_addr     <= w_addr;
            r_data     <= w_data;
            r_pll_rst  <= w_pll_rst;
            r_busy     <= w_busy;
            r_done     <= w_done;
            r_error    <= w_error;
            r_cur_mode <= w_cur_mode;
            r_ready    <= w_ready;
        end
    end

    assign mode_req_ready = r_ready;
    assign tbl_mode       = r_mode;
    assign tbl_index      = r_idx;
    assign mgmt_address   = r_addr;
    assign mgmt_writedata = r_data;
    assign mgmt_write     = r_wr;
    assign pll_rst        = r_pll_rst;
    assign busy           = r_busy;
    assign done           = r_done;
    assign error          = r_error;
    assign cur_mode       = r_cur_mode;

endmodule

// File: tb/tb_pll_reconfig_seq.sv
// Bench for pll_reconfig_seq: randomized requests, a table/lock/waitrequest environment,
// and a scoreboard of expected management writes and per-request outcomes.
module tb_pll_reconfig_seq;

    localparam int NUM_MODES    = 3;
    localparam int MAX_WRITES   = 5;
    localparam int ADDR_W       = 6;
    localparam int DATA_W       = 32;
    localparam int MODE_ADDR    = 0;
    localparam int START_ADDR   = 2;
    localparam int LOCK_TIMEOUT = 30;
    localparam int MAX_RETRY    = 3;
    localparam int RST_CYCLES   = 4;
    localparam int MW           = 2;
    localparam int IW           = 3;

    logic              clk;
    logic              reset_n;
    logic [MW-1:0]     mode_req;
    logic              mode_req_valid;
    logic              mode_req_ready;
    logic [MW-1:0]     tbl_mode;
    logic [IW-1:0]     tbl_index;
    logic [ADDR_W-1:0] tbl_addr;
    logic [DATA_W-1:0] tbl_data;
    logic              tbl_last;
    logic [ADDR_W-1:0] mgmt_address;
    logic [DATA_W-1:0] mgmt_writedata;
    logic              mgmt_write;
    logic              mgmt_waitrequest;
    logic              pll_locked;
    logic              pll_rst;
    logic              busy;
    logic              done;
    logic              error;
    logic [MW-1:0]     cur_mode;

    pll_reconfig_seq #(
        .NUM_MODES(NUM_MODES), .MAX_WRITES(MAX_WRITES), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .MODE_ADDR(MODE_ADDR), .START_ADDR(START_ADDR), .LOCK_TIMEOUT(LOCK_TIMEOUT),
        .MAX_RETRY(MAX_RETRY), .RST_CYCLES(RST_CYCLES)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .mode_req(mode_req), .mode_req_valid(mode_req_valid), .mode_req_ready(mode_req_ready),
        .tbl_mode(tbl_mode), .tbl_index(tbl_index),
        .tbl_addr(tbl_addr), .tbl_data(tbl_data), .tbl_last(tbl_last),
        .mgmt_address(mgmt_address), .mgmt_writedata(mgmt_writedata),
        .mgmt_write(mgmt_write), .mgmt_waitrequest(mgmt_waitrequest),
        .pll_locked(pll_locked), .pll_rst(pll_rst),
        .busy(busy), .done(done), .error(error), .cur_mode(cur_mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } wr_t;

    typedef struct {
        bit err;
        int mode;
        int pulses;
        int dones;
    } out_t;

    wr_t  exp_wr[$];
    out_t exp_out[$];

    int n_chk  = 0;
    int n_fail = 0;
    int model_cur = 0;

    // Environment knobs shared between stimulus and drivers
    int cur_k     = 0;
    int stall_at  = -1;
    int stall_len = 0;
    int rnd_stall = 0;
    int wr_num    = 0;

    int          tbl_len [0:3];
    logic [31:0] tbl_mem [0:3][0:7];

    function automatic logic [ADDR_W-1:0] addr_of(input int m, input int i);
        return ADDR_W'(8 + 8 * m + i);
    endfunction

    always_comb begin
        tbl_addr = addr_of(int'(tbl_mode), int'(tbl_index));
        tbl_data = tbl_mem[tbl_mode][tbl_index];
        tbl_last = (tbl_len[tbl_mode] != 0) && (int'(tbl_index) == tbl_len[tbl_mode] - 1);
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic flag(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Waitrequest and lock driver: stalls chosen writes, asserts lock after the k-th PLL reset pulse
    initial begin
        int  stall_rem = 0;
        int  lock_cnt  = 0;
        int  drop_cnt  = 0;
        int  rst_seen  = 0;
        bit  in_wr     = 0;
        bit  prev_rst  = 0;
        mgmt_waitrequest = 1'b0;
        pll_locked       = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                stall_rem = 0; lock_cnt = 0; drop_cnt = 0; rst_seen = 0;
                in_wr = 0; prev_rst = 0;
                mgmt_waitrequest = 1'b0;
                pll_locked       = 1'b0;
            end else begin
                if (mgmt_write) begin
                    if (!in_wr) begin
                        in_wr = 1;
                        if (wr_num == stall_at)  stall_rem = stall_len;
                        else if (rnd_stall != 0) stall_rem = $urandom_range(0, 2);
                        else                     stall_rem = 0;
                    end
                    if (stall_rem > 0) begin
                        mgmt_waitrequest = 1'b1;
                        stall_rem--;
                    end else begin
                        mgmt_waitrequest = 1'b0;
                        in_wr = 0;
                        wr_num++;
                        if (int'(mgmt_address) == START_ADDR) begin
                            rst_seen = 0;
                            if (cur_k == 0) lock_cnt = 10;
                        end
                    end
                end else begin
                    mgmt_waitrequest = 1'b0;
                end
                if (prev_rst && !pll_rst) begin
                    rst_seen++;
                    if (rst_seen == cur_k) lock_cnt = 10;
                end
                prev_rst = pll_rst;
                if (lock_cnt > 0) begin
                    lock_cnt--;
                    if (lock_cnt == 0) pll_locked = 1'b1;
                end
                if (done) drop_cnt = 5;
                if (drop_cnt > 0) begin
                    drop_cnt--;
                    if (drop_cnt == 0) pll_locked = 1'b0;
                end
            end
        end
    end

    // Monitor: pops expected writes on completion, checks holds, pulse widths and outcomes
    initial begin
        bit                hold_v = 0;
        logic [ADDR_W-1:0] h_a = '0;
        logic [DATA_W-1:0] h_d = '0;
        int                rst_w = 0, pulses = 0, dones = 0;
        bit                prev_busy = 0, prev_rst = 0;
        wr_t               e;
        out_t              o;
        forever begin
            @(negedge clk);
            #2;
            if (!reset_n) begin
                hold_v = 0; rst_w = 0; pulses = 0; dones = 0; prev_busy = 0; prev_rst = 0;
            end else begin
                if (mgmt_write) begin
                    if (hold_v) begin
                        check("wr_hold_addr", 64'(mgmt_address), 64'(h_a));
                        check("wr_hold_data", 64'(mgmt_writedata), 64'(h_d));
                    end
                    if (mgmt_waitrequest) begin
                        hold_v = 1; h_a = mgmt_address; h_d = mgmt_writedata;
                    end else begin
                        hold_v = 0;
                        if (exp_wr.size() == 0) begin
                            flag($sformatf("unexpected_write addr=%0h data=%0h", mgmt_address, mgmt_writedata));
                        end else begin
                            e = exp_wr.pop_front();
                            check("wr_addr", 64'(mgmt_address), 64'(e.a));
                            check("wr_data", 64'(mgmt_writedata), 64'(e.d));
                        end
                    end
                end else if (hold_v) begin
                    flag("write_dropped_while_waitrequest");
                    hold_v = 0;
                end
                if (pll_rst) begin
                    rst_w++;
                end else if (prev_rst) begin
                    check("pll_rst_width", 64'(rst_w), 64'(RST_CYCLES));
                    pulses++;
                    rst_w = 0;
                end
                if (done) dones++;
                if (prev_busy && !busy) begin
                    if (exp_out.size() == 0) begin
                        flag("unexpected_completion");
                    end else begin
                        o = exp_out.pop_front();
                        check("out_error", 64'(error), 64'(o.err));
                        check("out_cur_mode", 64'(cur_mode), 64'(o.mode));
                        check("out_rst_pulses", 64'(pulses), 64'(o.pulses));
                        check("out_done_cycles", 64'(dones), 64'(o.dones));
                        check("out_writes_left", 64'(exp_wr.size()), 64'(0));
                    end
                    pulses = 0;
                    dones  = 0;
                end
                prev_busy = busy;
                prev_rst  = pll_rst;
            end
        end
    end

    // Reference: expected write list and outcome derived from mode, table length and lock behaviour
    task automatic issue_req(input int m, input int len, input int k,
                             input int s_at, input int s_len, input int rnd);
        int   n;
        bit   ok;
        out_t o;
        tbl_len[m] = len;
        for (int i = 0; i < 8; i++) tbl_mem[m][i] = $urandom;
        cur_k = k; stall_at = s_at; stall_len = s_len; rnd_stall = rnd; wr_num = 0;
        ok = (m < NUM_MODES) && (k <= MAX_RETRY);
        if (m < NUM_MODES) begin
            exp_wr.push_back('{a: ADDR_W'(MODE_ADDR), d: '0});
            n = (len == 0 || len > MAX_WRITES) ? MAX_WRITES : len;
            for (int i = 0; i < n; i++) exp_wr.push_back('{a: addr_of(m, i), d: tbl_mem[m][i]});
            exp_wr.push_back('{a: ADDR_W'(START_ADDR), d: '0});
        end
        if (ok) model_cur = m;
        o.err    = !ok;
        o.mode   = model_cur;
        o.pulses = (m < NUM_MODES) ? ((k < MAX_RETRY) ? k : MAX_RETRY) : 0;
        o.dones  = ok ? 1 : 0;
        exp_out.push_back(o);
        for (int c = 0; c < 200 && !mode_req_ready; c++) @(negedge clk);
        if (!mode_req_ready) flag("timeout_ready");
        mode_req       = MW'(m);
        mode_req_valid = 1'b1;
        @(negedge clk);
        mode_req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit seen = 0;
        for (int c = 0; c < 3000; c++) begin
            if (!busy) begin
                seen = 1;
                break;
            end
            mode_req_valid = 1'($urandom_range(0, 1));
            mode_req       = MW'($urandom);
            @(negedge clk);
        end
        mode_req_valid = 1'b0;
        if (!seen) flag("timeout_idle");
        repeat (12) @(negedge clk);
        check("idle_busy_after_lock_drop", 64'(busy), 64'(0));
        check("idle_ready", 64'(mode_req_ready), 64'(1));
    endtask

    task automatic run_req(input int m, input int len, input int k,
                           input int s_at, input int s_len, input int rnd);
        issue_req(m, len, k, s_at, s_len, rnd);
        wait_idle();
    endtask

    initial begin
        bit seen;
        reset_n        = 1'b0;
        mode_req       = '0;
        mode_req_valid = 1'b0;
        for (int m = 0; m < 4; m++) begin
            tbl_len[m] = 1;
            for (int i = 0; i < 8; i++) tbl_mem[m][i] = '0;
        end
        repeat (3) @(negedge clk);
        check("rst_ready", 64'(mode_req_ready), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_error", 64'(error), 64'(0));
        check("rst_cur_mode", 64'(cur_mode), 64'(0));
        check("rst_pll_rst", 64'(pll_rst), 64'(0));
        check("rst_mgmt_write", 64'(mgmt_write), 64'(0));
        check("rst_mgmt_address", 64'(mgmt_address), 64'(0));
        check("rst_mgmt_writedata", 64'(mgmt_writedata), 64'(0));
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        run_req(2, 3, 0, -1, 0, 0);          // nominal
        run_req(1, 3, 0, 2, 4, 0);           // stall on second table write
        run_req(0, 2, 2, -1, 0, 0);          // two timeouts then lock
        run_req(1, 2, 99, -1, 0, 0);         // lock never arrives
        run_req(2, 1, 0, -1, 0, 0);          // clears error
        run_req(3, 2, 0, -1, 0, 0);          // out-of-range mode
        run_req(1, 0, 0, -1, 0, 0);          // tbl_last never set

        // Reset while table writes are in progress
        issue_req(1, 4, 0, -1, 0, 0);
        seen = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (mgmt_write && mgmt_address >= 6'd8) begin
                seen = 1;
                break;
            end
        end
        if (!seen) flag("timeout_load_write");
        reset_n = 1'b0;
        exp_wr.delete();
        exp_out.delete();
        model_cur = 0;
        #1;
        check("rst_mid_mgmt_write", 64'(mgmt_write), 64'(0));
        check("rst_mid_busy", 64'(busy), 64'(0));
        check("rst_mid_cur_mode", 64'(cur_mode), 64'(0));
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        run_req(1, 4, 0, -1, 0, 0);

        for (int t = 0; t < 15; t++) begin
            run_req($urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 4), -1, 0, 1);
        end

        check("final_exp_out_empty", 64'(exp_out.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pll_reconfig_seq.md
PLL_RECONFIG_SEQ -- requirements
Module: pll_reconfig_seq

Interface
REQ-001 SHALL have parameter NUM_MODES, default 4: number of selectable PLL output-frequency modes.
REQ-002 SHALL have parameter MAX_WRITES, default 16: upper limit on counter-register writes per mode.
REQ-003 SHALL have parameter ADDR_W, default 6: management address width.
REQ-004 SHALL have parameter DATA_W, default 32: management data width.
REQ-005 SHALL have parameter MODE_ADDR, default 0, and START_ADDR, default 2: reconfig mode register and start register addresses.
REQ-006 SHALL have parameter LOCK_TIMEOUT, default 65535: cycles to wait for lock per attempt.
REQ-007 SHALL have parameter MAX_RETRY, default 3: PLL reset retries after a lock timeout.
REQ-008 SHALL have parameter RST_CYCLES, default 16: width of the pll_rst pulse.
REQ-009 SHALL have port clk, input, 1 bit: single clock, with all logic on its rising edge.
REQ-010 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-011 SHALL have port mode_req, input, MW bits, where MW = max(1, clog2(NUM_MODES)): requested mode.
REQ-012 SHALL have ports mode_req_valid (input, 1) and mode_req_ready (output, 1): request handshake.
REQ-013 SHALL have port tbl_mode, output, MW bits, and port tbl_index, output, clog2(MAX_WRITES) bits: table lookup key.
REQ-014 SHALL have ports tbl_addr (input, ADDR_W), tbl_data (input, DATA_W) and tbl_last (input, 1): combinational zero-latency table response.
REQ-015 SHALL have ports mgmt_address (output, ADDR_W), mgmt_writedata (output, DATA_W), mgmt_write (output, 1) and mgmt_waitrequest (input, 1): PLL reconfig management port.
REQ-016 SHALL have port pll_locked, input, 1 bit: asynchronous lock indication.
REQ-017 SHALL have port pll_rst, output, 1 bit: active-high PLL reset.
REQ-018 SHALL have ports busy (output, 1), done (output, 1-cycle pulse), error (output, 1, sticky) and cur_mode (output, MW).

Function
REQ-019 SHALL synchronise pll_locked through 2 flops; all uses of lock SHALL refer to the synchronised value lk.
REQ-020 SHALL drive mode_req_ready = 1 only in IDLE; a request SHALL be accepted when valid && ready, and the mode SHALL be latched.
REQ-021 SHALL have states IDLE, MODE, LOAD, START, WAIT_LOCK, PRST, DONE and FAIL.
REQ-022 SHALL go from IDLE on accept to MODE, clearing error; if the requested mode is >= NUM_MODES, it SHALL instead go to FAIL with no mgmt writes.
REQ-023 SHALL, in MODE, write MODE_ADDR with data 0, then go to LOAD with index 0.
REQ-024 SHALL, in LOAD, write tbl_addr/tbl_data for the current index; after it completes, go to START if tbl_last or index = MAX_WRITES-1, else increment the index.
REQ-025 SHALL, in START, write START_ADDR with data 0, then go to WAIT_LOCK with the timer cleared.
REQ-026 SHALL treat a write as complete on the cycle mgmt_write && !mgmt_waitrequest; address, data and write SHALL hold stable while waitrequest = 1; mgmt_write SHALL be 0 outside write cycles.
REQ-027 SHALL, in WAIT_LOCK, go to DONE if lk = 1 at timer >= 1; if the timer reaches LOCK_TIMEOUT, it SHALL go to PRST when retries < MAX_RETRY, else to FAIL.
REQ-028 SHALL, in PRST, hold pll_rst = 1 for exactly RST_CYCLES cycles, increment the retry count, then return to WAIT_LOCK with the timer cleared.
REQ-029 SHALL, in DONE, pulse done for 1 cycle, update cur_mode to the latched mode, and return to IDLE.
REQ-030 SHALL, in FAIL, set error = 1, leave cur_mode unchanged, and return to IDLE.
REQ-031 SHALL drive busy = 1 in every state except IDLE.
REQ-032 SHALL drive tbl_mode to the latched mode and tbl_index to the current index at all times.
REQ-033 SHALL keep the timer saturating and the retry counter clog2(MAX_RETRY+1) bits wide; neither SHALL wrap.
REQ-034 SHALL ignore mode_req_valid while busy; no queuing.
REQ-035 SHALL ignore a drop of lk after DONE; no auto-retrigger.

Reset
REQ-036 SHALL, on reset_n = 0, asynchronously force: state IDLE, mode_req_ready = 0 during reset, busy = 0, done = 0, error = 0, cur_mode = 0, pll_rst = 0, mgmt_write = 0, mgmt_address = 0, mgmt_writedata = 0, all counters 0, and sync flops 0.
REQ-037 SHALL, if reset_n is asserted mid-sequence, abort the sequence with no further writes; operation SHALL restart from IDLE after release.

Verification
REQ-038 SHALL cover a nominal sequence: mode 2, table of 3 entries, waitrequest = 0, lock 10 cycles after start -> 5 writes (MODE_ADDR, 3 table entries, START_ADDR), done pulse, cur_mode = 2, error = 0.
REQ-039 SHALL cover waitrequest stall: waitrequest held 4 cycles on the 2nd table write -> address/data stable for 5 cycles, exactly one write completes, order preserved.
REQ-040 SHALL cover retry: lock absent for 2 timeouts, then present -> 2 pll_rst pulses of RST_CYCLES each, then done, error = 0.
REQ-041 SHALL cover the failure path: lock never asserts -> MAX_RETRY pll_rst pulses, then error = 1, cur_mode unchanged, and the next request clears error.
REQ-042 SHALL cover out-of-range and overflow cases: mode = NUM_MODES -> error with no writes; tbl_last never set -> exactly MAX_WRITES table writes, then START.
REQ-043 SHALL cover reset mid-sequence: reset_n low during LOAD -> mgmt_write = 0 and busy = 0 immediately, and after release a new request runs the full sequence.
